// File: rtl/des_key_mix.sv
// des_key_mix: DES round-key schedule plus E-expansion / key XOR stage.
// Takes one 32-bit right half R per handshake and registers
// E(R) ^ K(round) as eight 6-bit S-box fields.
// The schedule advances one round per accepted word and wraps after 16.
// Optional feature: define DES_KEYMIX_PARITY_CHK_EN to flag keys whose
// bytes are not odd parity on wKeyParErr. Otherwise wKeyParErr is tied low.
module des_key_mix (
  input  logic        wClk,
  input  logic        wRstN,
  input  logic        wKeyLoad,
  input  logic [63:0] wKey,
  input  logic        wDecrypt,
  input  logic        wRValid,
  input  logic [31:0] wRData,
  output logic        wRReady,
  output logic        wMixValid,
  output logic [47:0] wMixData,
  input  logic        wMixReady,
  output logic [3:0]  wRound,
  output logic        wLastRound,
  output logic        wKeyParErr
);

  typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} mode_e;

  // FIPS 46-3 tables in DES bit numbering (bit 1 = MSB).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return o;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = r[5'(32 - E_TAB[i])];
    return o;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[26:0], v[27]};
      2'd2:    return {v[25:0], v[27:26]};
      default: return v;
    endcase
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[0], v[27:1]};
      2'd2:    return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  cnt_q;
  mode_e       mode_q;
  logic        wrapped_q;
  logic [1:0]  amt;
  logic        single;
  logic        accept;
  logic [47:0] subkey;

  assign wRReady = ~wKeyLoad & (~wMixValid | wMixReady);
  assign accept  = wRValid & wRReady;
  assign subkey  = pc2({c_nxt, d_nxt});

  // Rotation for the round being accepted: left in encrypt, right in decrypt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    amt    = 2'd2;
    c_nxt  = c_q;
    d_nxt  = d_q;
    single = (cnt_q == 4'd0) || (cnt_q == 4'd1) || (cnt_q == 4'd8) || (cnt_q == 4'd15);
    if (mode_q == MODE_ENC) begin
      amt   = single ? 2'd1 : 2'd2;
      c_nxt = rotl(c_q, amt);
      d_nxt = rotl(d_q, amt);
    end else begin
      // Decrypt round 1 uses C16 = C0 directly after a load. On later passes
      // the state sits one left of C0 (encrypt round 1 is never undone), so
      // a single right step brings it back and the schedule repeats cleanly.
      if (cnt_q == 4'd0) amt = wrapped_q ? 2'd1 : 2'd0;
      else               amt = single ? 2'd1 : 2'd2;
      c_nxt = rotr(c_q, amt);
      d_nxt = rotr(d_q, amt);
    end
  end

  // Key schedule state: reload on wKeyLoad, advance one round per accept.
  always_ff @(posedge wClk or negedge wRstN) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!wRstN) begin
      c_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_ENC;
      wrapped_q <= 1'b0;
    end else if (wKeyLoad) begin
      c_q       <= pc1(wKey)[55:28];
      d_q       <= pc1(wKey)[27:0];
      cnt_q     <= '0;
      mode_q    <= wDecrypt ? MODE_DEC : MODE_ENC;
      wrapped_q <= 1'b0;
    end else if (accept) begin
      c_q   <= c_nxt;
      d_q   <= d_nxt;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) wrapped_q <= 1'b1;
    end
  end

  // Single-entry output register with valid/ready handshake.
  always_ff @(posedge wClk or negedge wRstN) begin
    // NOTE: the data register is reset too, so wMixData reads zero after reset.
    if (!wRstN) begin
      wMixValid  <= 1'b0;
      wMixData   <= '0;
      wRound     <= '0;
      wLastRound <= 1'b0;
    end else if (accept) begin
      wMixValid  <= 1'b1;
      wMixData   <= expand(wRData) ^ subkey;
      wRound     <= cnt_q;
      wLastRound <= (cnt_q == 4'd15);
    end else if (wMixValid && wMixReady) begin
      wMixValid  <= 1'b0;
    end
  end

`ifdef DES_KEYMIX_PARITY_CHK_EN
  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (^k[b*8 +: 8] == 1'b0) bad = 1'b1;
    return bad;
  endfunction

  // Sticky until the next load: each load re-evaluates the key's byte parity.
  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN)        wKeyParErr <= 1'b0;
    else if (wKeyLoad) wKeyParErr <= parity_bad(wKey);
  end
`else
  assign wKeyParErr = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_mix.sv
// Scoreboard bench for des_key_mix: a reference key schedule built from
// cumulative DES shift counts predicts every output word.
module tb_des_key_mix;

  logic        wClk = 1'b0;
  logic        wRstN;
  logic        wKeyLoad;
  logic [63:0] wKey;
  logic        wDecrypt;
  logic        wRValid;
  logic [31:0] wRData;
  logic        wRReady;
  logic        wMixValid;
  logic [47:0] wMixData;
  logic        wMixReady;
  logic [3:0]  wRound;
  logic        wLastRound;
  logic        wKeyParErr;

  des_key_mix dut (
    .wClk(wClk), .wRstN(wRstN), .wKeyLoad(wKeyLoad), .wKey(wKey),
    .wDecrypt(wDecrypt), .wRValid(wRValid), .wRData(wRData), .wRReady(wRReady),
    .wMixValid(wMixValid), .wMixData(wMixData), .wMixReady(wMixReady),
    .wRound(wRound), .wLastRound(wLastRound), .wKeyParErr(wKeyParErr)
  );

  always #5 wClk = ~wClk;

`ifdef DES_KEYMIX_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int ETAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  // Total left shift of C/D at encrypt round r (index r-1).
  localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  typedef struct {
    logic [47:0] mix;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [47:0] out_log[$];
  logic        last_log[$];
  logic [47:0] last_out;
  logic [55:0] m_cd0;
  logic        m_dec;
  int          m_cnt;
  logic        m_par;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pat [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55 - i] = k[64 - PC1[i]];
    return o;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47 - i] = cd[56 - PC2[i]];
    return o;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] r);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47 - i] = r[32 - ETAB[i]];
    return o;
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] v, input int n);
    return (v << n) | (v >> (28 - n));
  endfunction

  // Subkey K(idx+1) straight from the loaded C0/D0.
  function automatic logic [47:0] f_subkey(input logic [55:0] cd0, input int idx);
    logic [27:0] c, d;
    c = f_rotl(cd0[55:28], CUM[idx]);
    d = f_rotl(cd0[27:0], CUM[idx]);
    return f_pc2({c, d});
  endfunction

  function automatic logic f_par_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (^k[b*8 +: 8] == 1'b0) bad = 1'b1;
    return bad;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, update the model.
  task automatic step(input logic load, input logic [63:0] key, input logic dec,
                      input logic rv, input logic [31:0] rd, input logic mr);
    logic exp_valid, exp_ready;
    exp_t e;
    wKeyLoad = load; wKey = key; wDecrypt = dec;
    wRValid = rv; wRData = rd; wMixReady = mr;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = !load && (!exp_valid || mr);
    check("mix_valid", wMixValid, exp_valid);
    check("r_ready", wRReady, exp_ready);
    check("par_err", wKeyParErr, m_par);
    if (exp_valid) begin
      check("mix_data", wMixData, q[0].mix);
      check("round", wRound, q[0].rnd);
      check("last_round", wLastRound, q[0].last);
      if (mr) begin
        void'(q.pop_front());
        last_out = wMixData;
        out_log.push_back(wMixData);
        last_log.push_back(wLastRound);
      end
    end
    if (rv && exp_ready) begin
      e.mix  = f_e(rd) ^ f_subkey(m_cd0, m_dec ? 15 - m_cnt : m_cnt);
      e.rnd  = 4'(m_cnt);
      e.last = (m_cnt == 15);
      q.push_back(e);
      m_cnt = (m_cnt + 1) % 16;
    end
    if (load) begin
      m_cd0 = f_pc1(key);
      m_dec = dec;
      m_cnt = 0;
      m_par = PAR_EN && f_par_bad(key);
    end
    @(negedge wClk);
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic model_reset();
    q.delete();
    m_cd0 = '0; m_dec = 1'b0; m_cnt = 0; m_par = 1'b0;
  endtask

  initial begin
    int base;
    model_reset();
    wRstN = 1'b0; wKeyLoad = 1'b0; wKey = '0; wDecrypt = 1'b0;
    wRValid = 1'b0; wRData = '0; wMixReady = 1'b0;
    last_out = '0;
    for (int i = 0; i < 16; i++) pat[i] = $urandom;
    repeat (2) @(negedge wClk);
    #1;
    check("rst_valid", wMixValid, 1'b0);
    check("rst_data", wMixData, 48'h0);
    check("rst_round", wRound, 4'h0);
    check("rst_last", wLastRound, 1'b0);
    check("rst_parerr", wKeyParErr, 1'b0);
    @(negedge wClk);
    wRstN = 1'b1;
    @(negedge wClk);

    // Known encrypt vector: K1 of the textbook key.
    step(1'b1, KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, KEY, 1'b0, 1'b1, 32'hF0AAF0AA, 1'b1);
    idle();
    check("tv_enc", last_out, 48'h6117BA866527);

    // Decrypt schedule starts at K16.
    step(1'b1, KEY, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, KEY, 1'b1, 1'b1, 32'h0, 1'b1);
    idle();
    check("tv_dec", last_out, 48'hCB3D8B0E17F5);

    // 32 back-to-back words: schedule wraps without reload.
    step(1'b1, KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    out_log.delete(); last_log.delete();
    for (int i = 0; i < 32; i++) step(1'b0, KEY, 1'b0, 1'b1, pat[i % 16], 1'b1);
    idle();
    check("b2b_count", out_log.size(), 32);
    if (out_log.size() == 32) begin
      for (int i = 0; i < 16; i++) check("wrap_repeat", out_log[16 + i], out_log[i]);
      for (int i = 0; i < 32; i++) check("last_pos", last_log[i], (i == 15) || (i == 31));
    end

    // Backpressure: 5 stalled cycles with a word waiting.
    base = out_log.size();
    step(1'b0, KEY, 1'b0, 1'b1, 32'h12345678, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, KEY, 1'b0, 1'b1, 32'h9ABCDEF0, 1'b0);
    step(1'b0, KEY, 1'b0, 1'b1, 32'h9ABCDEF0, 1'b1);
    idle();
    check("stall_count", out_log.size() - base, 2);

    // Reload mid-sequence, colliding with a valid word.
    step(1'b1, KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, KEY, 1'b0, 1'b1, pat[i], 1'b1);
    step(1'b1, KEY2, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
    step(1'b0, KEY2, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
    idle();
    check("reload_k1", last_out, f_e(32'hCAFEF00D) ^ f_subkey(f_pc1(KEY2), 0));

    // Key parity flag.
    step(1'b1, 64'h133457799BBCDFF0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    check("par_bad", wKeyParErr, PAR_EN);
    step(1'b1, KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    check("par_good", wKeyParErr, 1'b0);

    // Reset with an output pending, then a word with no key loaded.
    step(1'b1, KEY, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, KEY, 1'b0, 1'b1, 32'hF0AAF0AA, 1'b0);
    wRstN = 1'b0;
    #1;
    check("rst_mid_valid", wMixValid, 1'b0);
    check("rst_mid_data", wMixData, 48'h0);
    model_reset();
    @(negedge wClk);
    wRstN = 1'b1;
    step(1'b0, 64'h0, 1'b0, 1'b1, 32'hF0AAF0AA, 1'b1);
    idle();
    check("nokey_e", last_out, 48'h7A15557A1555);

    // Drain anything left, bounded.
    for (int i = 0; i < 10 && q.size() != 0; i++) idle();
    check("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
